// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory channels around the arbiter.
// The arbiter connects through the slave view; the surrounding core and memory use the master view.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single-outstanding memory port,
// round-robin on conflict, with a per-transaction response timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IFU = 2'd1, OWN_LSU = 2'd2} owner_t;

  // Timeout fires in the cycle the counter would reach TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        last_lsu;
  logic [15:0] cnt;

  logic        grant;
  logic        pick_lsu;
  logic        expired;
  logic        done;
  logic        abort;

  logic [31:0] lat_addr;
  logic        lat_wen;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic        mem_req_valid;

  assign pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
  assign expired  = (state != IDLE) && (cnt == TO_LAST);

  always_comb begin
    state_nxt         = state;
    owner_nxt         = owner;
    grant             = 1'b0;
    done              = 1'b0;
    abort             = 1'b0;
    mem_req_valid     = 1'b0;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
          grant             = 1'b1;
          bus.ifu_req_ready = !pick_lsu;
          bus.lsu_req_ready = pick_lsu;
          owner_nxt         = pick_lsu ? OWN_LSU : OWN_IFU;
          state_nxt         = REQ;
        end
      end
      REQ: begin
        // Drop the request on abort so memory never accepts an orphaned access.
        if (expired) begin
          abort     = 1'b1;
          owner_nxt = OWN_NONE;
          state_nxt = IDLE;
        end else begin
          mem_req_valid = 1'b1;
          if (bus.mem_req_ready) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          done      = 1'b1;
          owner_nxt = OWN_NONE;
          state_nxt = IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          owner_nxt = OWN_NONE;
          state_nxt = IDLE;
        end
      end
      default: begin
        owner_nxt = OWN_NONE;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      last_lsu <= 1'b1;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (grant) begin
        last_lsu <= pick_lsu;
        cnt      <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Request fields are only observed while mem_req_valid is high, so they need no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      lat_addr  <= pick_lsu ? bus.lsu_addr : bus.ifu_addr;
      lat_wen   <= pick_lsu && bus.lsu_wen;
      lat_wdata <= pick_lsu ? bus.lsu_wdata : 32'd0;
      lat_wmask <= pick_lsu ? bus.lsu_wmask : 4'b0000;
    end
  end

  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_addr      = mem_req_valid ? lat_addr  : 32'd0;
  assign bus.mem_wen       = mem_req_valid && lat_wen;
  assign bus.mem_wdata     = mem_req_valid ? lat_wdata : 32'd0;
  assign bus.mem_wmask     = mem_req_valid ? lat_wmask : 4'b0000;

  assign bus.ifu_resp_valid = (done || abort) && (owner == OWN_IFU);
  assign bus.ifu_resp_err   = abort && (owner == OWN_IFU);
  assign bus.ifu_rdata      = (done && (owner == OWN_IFU)) ? bus.mem_rdata : 32'd0;

  assign bus.lsu_resp_valid = (done || abort) && (owner == OWN_LSU);
  assign bus.lsu_resp_err   = abort && (owner == OWN_LSU);
  assign bus.lsu_rdata      = (done && (owner == OWN_LSU)) ? bus.mem_rdata : 32'd0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a long-timeout instance for arbitration and data
// paths, plus a TIMEOUT=4 instance for abort and precedence cases.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  typedef struct packed {
    logic        lsu;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, busy4;

  mem_arbiter_if io ();
  mem_arbiter_if io4 ();

  mem_arbiter #(.TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(io.slave), .busy(busy));
  mem_arbiter #(.TIMEOUT(4))  dut4 (.clk(clk), .rst(rst), .bus(io4.slave), .busy(busy4));

  always #5 clk = ~clk;

  mreq_t ifu_q[$];
  mreq_t lsu_q[$];
  mreq_t mexp_q[$];
  resp_t rexp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int stall_cfg = 0;
  int resp_dly  = 0;
  bit resp_en   = 1'b1;
  bit inject    = 1'b0;

  logic        s_hs = 1'b0, s_ifu_hs = 1'b0, s_lsu_hs = 1'b0;
  logic [31:0] s_addr = 32'd0;
  resp_t       mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic add_ifu(input logic [31:0] a);
    mreq_t r;
    r = '{addr: a, wen: 1'b0, wdata: 32'd0, wmask: 4'b0000};
    ifu_q.push_back(r);
    mexp_q.push_back(r);
    rexp_q.push_back('{lsu: 1'b0, err: 1'b0, rdata: model(a)});
  endtask

  task automatic add_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input bit expect_resp);
    mreq_t r;
    r = '{addr: a, wen: w, wdata: d, wmask: m};
    lsu_q.push_back(r);
    mexp_q.push_back(r);
    if (expect_resp) rexp_q.push_back('{lsu: 1'b1, err: 1'b0, rdata: model(a)});
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((ifu_q.size() != 0 || lsu_q.size() != 0 || mexp_q.size() != 0 ||
            rexp_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, 32'(k < 300), 32'd1);
  endtask

  // Monitor: mem request fields against the expected-request queue, responses against the scoreboard.
  always @(negedge clk) begin
    s_hs     = io.mem_req_valid && io.mem_req_ready;
    s_addr   = io.mem_addr;
    s_ifu_hs = io.ifu_req_valid && io.ifu_req_ready;
    s_lsu_hs = io.lsu_req_valid && io.lsu_req_ready;
    if (!rst) begin
      if (io.mem_req_valid) begin
        if (mexp_q.size() == 0) begin
          check("mem_req_unexpected", 32'd1, 32'd0);
        end else begin
          check("mem_addr",  io.mem_addr,        mexp_q[0].addr);
          check("mem_wen",   32'(io.mem_wen),    32'(mexp_q[0].wen));
          check("mem_wdata", io.mem_wdata,       mexp_q[0].wdata);
          check("mem_wmask", 32'(io.mem_wmask),  32'(mexp_q[0].wmask));
          if (s_hs) void'(mexp_q.pop_front());
        end
      end else begin
        check("mem_addr_idle",  io.mem_addr,  32'd0);
        check("mem_wdata_idle", io.mem_wdata, 32'd0);
      end
      if (io.ifu_resp_valid || io.lsu_resp_valid) begin
        check("resp_onehot", 32'(io.ifu_resp_valid && io.lsu_resp_valid), 32'd0);
        if (rexp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = rexp_q.pop_front();
          check("resp_port", 32'(io.lsu_resp_valid), 32'(mon_e.lsu));
          check("resp_err", 32'(mon_e.lsu ? io.lsu_resp_err : io.ifu_resp_err), 32'(mon_e.err));
          check("resp_rdata", mon_e.lsu ? io.lsu_rdata : io.ifu_rdata, mon_e.rdata);
        end
      end
      if (!io.ifu_resp_valid) check("ifu_rdata_idle", io.ifu_rdata, 32'd0);
      if (!io.lsu_resp_valid) check("lsu_rdata_idle", io.lsu_rdata, 32'd0);
    end
  end

  initial begin : ifu_drv
    io.ifu_req_valid = 1'b0;
    io.ifu_addr      = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (s_ifu_hs && ifu_q.size() != 0) void'(ifu_q.pop_front());
      io.ifu_req_valid = (ifu_q.size() != 0);
      io.ifu_addr      = (ifu_q.size() != 0) ? ifu_q[0].addr : 32'd0;
    end
  end

  initial begin : lsu_drv
    io.lsu_req_valid = 1'b0;
    io.lsu_addr      = 32'd0;
    io.lsu_wen       = 1'b0;
    io.lsu_wdata     = 32'd0;
    io.lsu_wmask     = 4'b0000;
    forever begin
      @(posedge clk); #1;
      if (s_lsu_hs && lsu_q.size() != 0) void'(lsu_q.pop_front());
      io.lsu_req_valid = (lsu_q.size() != 0);
      io.lsu_addr      = (lsu_q.size() != 0) ? lsu_q[0].addr  : 32'd0;
      io.lsu_wen       = (lsu_q.size() != 0) ? lsu_q[0].wen   : 1'b0;
      io.lsu_wdata     = (lsu_q.size() != 0) ? lsu_q[0].wdata : 32'd0;
      io.lsu_wmask     = (lsu_q.size() != 0) ? lsu_q[0].wmask : 4'b0000;
    end
  end

  initial begin : mem_model
    int          stall_left;
    int          dly_left;
    bit          pend;
    logic [31:0] paddr;
    stall_left = 0;
    dly_left   = 0;
    pend       = 1'b0;
    paddr      = 32'd0;
    io.mem_req_ready  = 1'b0;
    io.mem_resp_valid = 1'b0;
    io.mem_rdata      = 32'd0;
    forever begin
      @(posedge clk); #1;
      io.mem_resp_valid = 1'b0;
      io.mem_rdata      = 32'd0;
      if (rst) begin
        pend = 1'b0;
      end else if (s_hs) begin
        pend     = 1'b1;
        paddr    = s_addr;
        dly_left = resp_dly;
      end
      if (inject) begin
        io.mem_resp_valid = 1'b1;
        io.mem_rdata      = 32'hDEAD_BEEF;
      end else if (pend && resp_en) begin
        if (dly_left == 0) begin
          io.mem_resp_valid = 1'b1;
          io.mem_rdata      = model(paddr);
          pend              = 1'b0;
        end else begin
          dly_left--;
        end
      end
      if (io.mem_req_valid) begin
        io.mem_req_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        io.mem_req_ready = 1'b0;
        stall_left       = stall_cfg;
      end
    end
  end

  // One transaction on the TIMEOUT=4 instance; resp_k selects the cycle after grant that carries mem_resp_valid.
  task automatic to_txn(input string tag, input bit lsu, input bit rdy, input int resp_k);
    logic rv, ov;
    @(posedge clk); #3;
    io4.mem_req_ready = rdy;
    if (lsu) begin
      io4.lsu_req_valid = 1'b1;
      io4.lsu_addr      = 32'h0000_2000;
      io4.lsu_wen       = 1'b1;
      io4.lsu_wdata     = 32'hA5A5_5A5A;
      io4.lsu_wmask     = 4'b1111;
    end else begin
      io4.ifu_req_valid = 1'b1;
      io4.ifu_addr      = 32'h0000_0100;
    end
    @(negedge clk);
    check({tag, "_ready"}, 32'(lsu ? io4.lsu_req_ready : io4.ifu_req_ready), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #3;
      io4.ifu_req_valid  = 1'b0;
      io4.lsu_req_valid  = 1'b0;
      io4.mem_resp_valid = (k == resp_k);
      io4.mem_rdata      = (k == resp_k) ? 32'hCAFE_F00D : 32'd0;
      @(negedge clk);
      rv = lsu ? io4.lsu_resp_valid : io4.ifu_resp_valid;
      ov = lsu ? io4.ifu_resp_valid : io4.lsu_resp_valid;
      check({tag, "_other_port"}, 32'(ov), 32'd0);
      if (!rdy) check({tag, "_mem_valid"}, 32'(io4.mem_req_valid), 32'(k < 4));
      if (k < 4) begin
        check({tag, "_early"}, 32'(rv), 32'd0);
      end else begin
        check({tag, "_resp_valid"}, 32'(rv), 32'd1);
        check({tag, "_resp_err"}, 32'(lsu ? io4.lsu_resp_err : io4.ifu_resp_err),
              32'(resp_k != 4));
        check({tag, "_rdata"}, lsu ? io4.lsu_rdata : io4.ifu_rdata,
              (resp_k == 4) ? 32'hCAFE_F00D : 32'd0);
      end
    end
    @(posedge clk); #3;
    io4.mem_resp_valid = 1'b0;
    io4.mem_rdata      = 32'd0;
    io4.mem_req_ready  = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy4), 32'd0);
    check({tag, "_no_second"}, 32'(io4.ifu_resp_valid || io4.lsu_resp_valid), 32'd0);
  endtask

  initial begin : main
    int k;
    io4.ifu_req_valid  = 1'b0;
    io4.ifu_addr       = 32'd0;
    io4.lsu_req_valid  = 1'b0;
    io4.lsu_addr       = 32'd0;
    io4.lsu_wen        = 1'b0;
    io4.lsu_wdata      = 32'd0;
    io4.lsu_wmask      = 4'b0000;
    io4.mem_req_ready  = 1'b0;
    io4.mem_resp_valid = 1'b0;
    io4.mem_rdata      = 32'd0;

    // Both requesters queue two accesses while still in reset; round-robin predicts IFU, LSU, IFU, LSU.
    #3;
    add_ifu(32'h0000_1000);
    add_lsu(32'h0000_3000, 1'b0, 32'd0, 4'b0000, 1'b1);
    add_ifu(32'h0000_1004);
    add_lsu(32'h0000_3004, 1'b1, 32'hFFEE_DDCC, 4'b1100, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      32'(busy),                 32'd0);
    check("rst_ifu_ready", 32'(io.ifu_req_ready),     32'd0);
    check("rst_lsu_ready", 32'(io.lsu_req_ready),     32'd0);
    check("rst_mem_valid", 32'(io.mem_req_valid),     32'd0);
    check("rst_resp",      32'(io.ifu_resp_valid || io.lsu_resp_valid), 32'd0);
    check("rst_busy4",     32'(busy4),                32'd0);

    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    check("first_grant_ifu", 32'(io.ifu_req_ready), 32'd1);
    check("first_grant_lsu", 32'(io.lsu_req_ready), 32'd0);
    @(negedge clk);
    check("n1_mem_valid", 32'(io.mem_req_valid), 32'd1);
    check("n1_busy",      32'(busy),             32'd1);
    check("n1_no_ready",  32'(io.ifu_req_ready || io.lsu_req_ready), 32'd0);
    @(negedge clk);
    check("n2_ifu_resp", 32'(io.ifu_resp_valid), 32'd1);
    @(negedge clk);
    check("n3_grant_lsu", 32'(io.lsu_req_ready), 32'd1);
    check("n3_ifu_wait",  32'(io.ifu_req_ready), 32'd0);
    wait_idle("tie");

    // Fetch returning a known instruction word.
    @(posedge clk); #3;
    add_ifu(32'h8000_0000);
    wait_idle("fetch");

    // Store held across three stalled cycles: four REQ cycles with stable fields.
    @(posedge clk); #3;
    stall_cfg = 3;
    add_lsu(32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011, 1'b1);
    k = 0;
    while (!io.mem_req_valid && k < 20) begin @(negedge clk); k++; end
    check("stall_seen", 32'(k < 20), 32'd1);
    k = 0;
    while (io.mem_req_valid && k < 20) begin @(negedge clk); k++; end
    check("stall_req_cycles", 32'(k), 32'd4);
    wait_idle("store");
    @(posedge clk); #3;
    stall_cfg = 0;

    // Mixed single transactions with varied stalls and response delays.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #3;
      stall_cfg = $urandom_range(0, 2);
      resp_dly  = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1)
        add_lsu($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
      else
        add_ifu($urandom);
      wait_idle("rand");
    end
    @(posedge clk); #3;
    stall_cfg = 0;
    resp_dly  = 0;

    // Reset while waiting on memory, followed by a stray response.
    resp_en = 1'b0;
    add_lsu(32'h0000_4000, 1'b0, 32'd0, 4'b0000, 1'b0);
    k = 0;
    while (!(busy && !io.mem_req_valid && mexp_q.size() == 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_wait_reached", 32'(k < 20), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_resp", 32'(io.lsu_resp_valid || io.ifu_resp_valid), 32'd0);
    @(posedge clk); #3;
    rst    = 1'b0;
    inject = 1'b1;
    @(posedge clk); #3;
    inject = 1'b0;
    @(negedge clk);
    check("late_resp_ifu", 32'(io.ifu_resp_valid), 32'd0);
    check("late_resp_lsu", 32'(io.lsu_resp_valid), 32'd0);
    check("late_resp_busy", 32'(busy), 32'd0);
    @(posedge clk); #3;
    resp_en = 1'b1;
    add_ifu(32'h0000_5000);
    wait_idle("post_rst");

    // Stray memory response while idle on the short-timeout instance.
    @(posedge clk); #3;
    io4.mem_resp_valid = 1'b1;
    io4.mem_rdata      = 32'h5555_AAAA;
    @(negedge clk);
    check("idle_resp_ignored", 32'(io4.ifu_resp_valid || io4.lsu_resp_valid), 32'd0);
    check("idle_resp_rdata", io4.ifu_rdata | io4.lsu_rdata, 32'd0);
    @(posedge clk); #3;
    io4.mem_resp_valid = 1'b0;
    io4.mem_rdata      = 32'd0;

    to_txn("to_wait", 1'b0, 1'b1, 0);
    to_txn("to_req",  1'b1, 1'b0, 2);
    to_txn("to_race", 1'b0, 1'b1, 4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
